// File: rtl/zl_ts_null_inserter.sv
// Transport-stream rate scheduler: at each packet boundary emits a whole user packet or a null packet.
// Latency: zero; user bytes pass combinationally and null bytes come from a local byte counter.
// Backpressure: data_out_ack gates every output transfer; in PASS it is forwarded straight to data_in_ack.
module zl_ts_null_inserter #(
  parameter int unsigned Pkt_len   = 188,
  parameter logic [12:0] Null_pid  = 13'h1FFF,
  parameter int unsigned Cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [7:0]           data_in,
  input  logic                 data_in_req,
  output logic                 data_in_ack,
  input  logic                 in_pkt_avail,
  output logic [7:0]           data_out,
  output logic                 data_out_req,
  input  logic                 data_out_ack,
  output logic [Cnt_width-1:0] null_pkt_count,
  output logic [Cnt_width-1:0] drop_byte_count
);

  typedef enum logic [1:0] {
    ST_DECIDE = 2'd0,
    ST_PASS   = 2'd1,
    ST_NULL   = 2'd2
  } state_t;

  localparam logic [7:0]           SyncByte = 8'h47;
  localparam logic [7:0]           LastIdx  = 8'(Pkt_len - 1);
  localparam logic [Cnt_width-1:0] CntMax   = '1;

  state_t               state_q, state_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic                 en_q, en_d;
  logic [Cnt_width-1:0] null_cnt_q, null_cnt_d;
  logic [Cnt_width-1:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]           null_byte;

  assign null_pkt_count  = null_cnt_q;
  assign drop_byte_count = drop_cnt_q;

  // Null packet content indexed by the position of the byte currently offered.
  always_comb begin
    null_byte = 8'hFF;
    case (byte_cnt_q)
      8'd0:    null_byte = SyncByte;
      8'd1:    null_byte = {3'b000, Null_pid[12:8]};
      8'd2:    null_byte = Null_pid[7:0];
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  end

  // Source selection, handshake steering and packet/statistics bookkeeping.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    en_d         = enable;
    null_cnt_d   = null_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    data_out     = 8'h00;
    data_out_req = 1'b0;
    data_in_ack  = 1'b0;

    case (state_q)
      ST_DECIDE: begin
        byte_cnt_d = 8'd0;
        if (en_q) begin
          if (data_in_req && (data_in == SyncByte) && in_pkt_avail) begin
            // Whole user packet is buffered and aligned: commit to it now.
            data_out     = data_in;
            data_out_req = 1'b1;
            data_in_ack  = data_out_ack;
            state_d      = ST_PASS;
            byte_cnt_d   = data_out_ack ? 8'd1 : 8'd0;
          end else if (data_in_req && (data_in != SyncByte)) begin
            // Out of alignment: swallow the byte and keep hunting for a sync byte.
            data_in_ack = 1'b1;
            if (drop_cnt_q != CntMax) begin
              drop_cnt_d = drop_cnt_q + 1'b1;
            end
          end else begin
            // Nothing ready in time: the null packet is committed once offered.
            data_out     = SyncByte;
            data_out_req = 1'b1;
            state_d      = ST_NULL;
            byte_cnt_d   = data_out_ack ? 8'd1 : 8'd0;
          end
        end
      end

      ST_PASS: begin
        // FIFO underflow mid-packet simply stalls the output, no filler is inserted.
        data_out     = data_in;
        data_out_req = data_in_req;
        data_in_ack  = data_out_ack;
        if (data_in_req && data_out_ack) begin
          if (byte_cnt_q == LastIdx) begin
            state_d    = ST_DECIDE;
            byte_cnt_d = 8'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      ST_NULL: begin
        data_out     = null_byte;
        data_out_req = 1'b1;
        if (data_out_ack) begin
          if (byte_cnt_q == LastIdx) begin
            state_d    = ST_DECIDE;
            byte_cnt_d = 8'd0;
            if (null_cnt_q != CntMax) begin
              null_cnt_d = null_cnt_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d    = ST_DECIDE;
        byte_cnt_d = 8'd0;
      end
    endcase
  end

  // State, byte index, enable sample and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DECIDE;
      byte_cnt_q <= 8'd0;
      en_q       <= 1'b0;
      null_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      en_q       <= en_d;
      null_cnt_q <= null_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_zl_ts_null_inserter.sv
`timescale 1ns/1ps
module tb_zl_ts_null_inserter;

  localparam int PKT  = 188;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [7:0]    data_in;
  logic          data_in_req;
  logic          data_in_ack;
  logic          in_pkt_avail;
  logic [7:0]    data_out;
  logic          data_out_req;
  logic          data_out_ack;
  logic [CW-1:0] null_pkt_count;
  logic [CW-1:0] drop_byte_count;

  always #5 clk = ~clk;

  zl_ts_null_inserter #(.Pkt_len(PKT), .Null_pid(13'h1FFF), .Cnt_width(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .data_in(data_in), .data_in_req(data_in_req), .data_in_ack(data_in_ack),
    .in_pkt_avail(in_pkt_avail),
    .data_out(data_out), .data_out_req(data_out_req), .data_out_ack(data_out_ack),
    .null_pkt_count(null_pkt_count), .drop_byte_count(drop_byte_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] in_q[$];    // bytes waiting in the input FIFO
  logic [7:0] out_q[$];   // bytes accepted downstream
  logic [7:0] user_q[$];  // user packets in the order they were queued
  int  junk_cnt;
  int  ack_pct, gap_pct;
  int  stab_viol, gap_cycles, zl_viol;
  bit  out_started, chk_zl, in_held;
  logic prev_req, prev_ack;
  logic [7:0] prev_dat;

  // Expected null packet byte from its position.
  function automatic logic [7:0] null_byte(input int i);
    if (i == 0) return 8'h47;
    if (i == 1) return 8'h1F;
    if (i == 2) return 8'hFF;
    if (i == 3) return 8'h10;
    return 8'hFF;
  endfunction

  // Packet-level model: split the output into packets, classify each as null or next user packet.
  function automatic void parse_stream(output int nulls, output int users, output int bad);
    int up;
    bit is_null, is_user;
    nulls = 0; users = 0; bad = 0; up = 0;
    for (int p = 0; p + PKT <= out_q.size(); p += PKT) begin
      is_null = 1'b1;
      is_user = (up + PKT <= user_q.size());
      for (int i = 0; i < PKT; i++) begin
        if (out_q[p+i] !== null_byte(i)) is_null = 1'b0;
        if (is_user && (out_q[p+i] !== user_q[up+i])) is_user = 1'b0;
      end
      if (is_user) begin users++; up += PKT; end
      else if (is_null) nulls++;
      else bad++;
    end
  endfunction

  function automatic logic [CW-1:0] sat(input int v);
    return CW'((v > CMAX) ? CMAX : v);
  endfunction

  task automatic drive();
    data_out_ack = ($urandom_range(99) < ack_pct);
    if (!in_held) data_in_req = (in_q.size() > 0) && ($urandom_range(99) >= gap_pct);
    data_in      = data_in_req ? in_q[0] : 8'h00;
    in_pkt_avail = (in_q.size() >= PKT);
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (prev_req && !prev_ack && (!data_out_req || data_out !== prev_dat)) stab_viol++;
    if (out_started && !data_out_req) gap_cycles++;
    if (chk_zl && data_out_req &&
        (data_out !== data_in || data_out_req !== data_in_req || data_in_ack !== data_out_ack)) zl_viol++;
    if (data_out_req && data_out_ack) begin out_q.push_back(data_out); out_started = 1'b1; end
    in_held = data_in_req && !data_in_ack;
    if (data_in_req && data_in_ack) void'(in_q.pop_front());
    prev_req = data_out_req; prev_ack = data_out_ack; prev_dat = data_out;
    @(posedge clk); #1;
    drive();
  endtask

  task automatic run_until_out(input int n, input int bound, output bit ok);
    int c;
    c = 0;
    while (out_q.size() < n && c < bound) begin tick(); c++; end
    ok = (out_q.size() >= n);
  endtask

  task automatic clear_model();
    in_q.delete(); out_q.delete(); user_q.delete();
    junk_cnt = 0; ack_pct = 100; gap_pct = 0;
    stab_viol = 0; gap_cycles = 0; zl_viol = 0;
    out_started = 1'b0; chk_zl = 1'b0; in_held = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_dat = 8'h00;
    data_in_req = 1'b0; data_in = 8'h00; in_pkt_avail = 1'b0; data_out_ack = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_pkt();
    logic [7:0] b;
    for (int i = 0; i < PKT; i++) begin
      b = (i == 0) ? 8'h47 : 8'($urandom_range(255));
      in_q.push_back(b); user_q.push_back(b);
    end
  endtask

  task automatic push_junk(input logic [7:0] v);
    in_q.push_back((v == 8'h47) ? 8'h00 : v);
    junk_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1 rst_n = 1'b0;
    clear_model();
    enable = 1'b1; data_in_req = 1'b1; data_in = 8'h47; in_pkt_avail = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data_out_req !== 1'b0) $display("FAIL rst_out_req: got %b want 0", data_out_req); else n_pass++;
    n_checks++; if (data_in_ack !== 1'b0) $display("FAIL rst_in_ack: got %b want 0", data_in_ack); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL rst_data_out: got %h want 00", data_out); else n_pass++;
    n_checks++; if (null_pkt_count !== sat(0)) $display("FAIL rst_null_cnt: got %0d want 0", null_pkt_count); else n_pass++;
    n_checks++; if (drop_byte_count !== sat(0)) $display("FAIL rst_drop_cnt: got %0d want 0", drop_byte_count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_null_stream();
    bit ok; int nn, nu, nb;
    do_reset();
    enable = 1'b1; drive();
    run_until_out(3*PKT - 1, 2000, ok);
    n_checks++; if (!ok) $display("FAIL null_wait: got %0d bytes want %0d", out_q.size(), 3*PKT-1); else n_pass++;
    n_checks++; if (null_pkt_count !== sat(2)) $display("FAIL null_cnt_before: got %0d want 2", null_pkt_count); else n_pass++;
    tick();
    n_checks++; if (null_pkt_count !== sat(3)) $display("FAIL null_cnt_after: got %0d want 3", null_pkt_count); else n_pass++;
    parse_stream(nn, nu, nb);
    n_checks++; if (nn != 3 || nb != 0 || nu != 0) $display("FAIL null_stream: got null=%0d user=%0d bad=%0d want 3/0/0", nn, nu, nb); else n_pass++;
    n_checks++; if (gap_cycles != 0) $display("FAIL null_bubbles: got %0d idle cycles want 0", gap_cycles); else n_pass++;
  endtask

  task automatic test_user_passthrough();
    bit ok; int nn, nu, nb;
    do_reset();
    push_pkt(); chk_zl = 1'b1; enable = 1'b1; drive();
    run_until_out(1, 20, ok);
    enable = 1'b0;
    run_until_out(PKT, 400, ok);
    repeat (20) tick();
    parse_stream(nn, nu, nb);
    n_checks++; if (out_q.size() != PKT) $display("FAIL pass_len: got %0d want %0d", out_q.size(), PKT); else n_pass++;
    n_checks++; if (nu != 1 || nb != 0 || nn != 0) $display("FAIL pass_content: got null=%0d user=%0d bad=%0d want 0/1/0", nn, nu, nb); else n_pass++;
    n_checks++; if (zl_viol != 0) $display("FAIL pass_zero_latency: got %0d violations want 0", zl_viol); else n_pass++;
    n_checks++; if (in_q.size() != 0) $display("FAIL pass_consumed: got %0d left want 0", in_q.size()); else n_pass++;
  endtask

  task automatic test_hunt();
    bit ok; int nn, nu, nb;
    do_reset();
    push_junk(8'h00); push_junk(8'h12); push_pkt();
    enable = 1'b1; drive();
    run_until_out(1, 50, ok);
    enable = 1'b0;
    run_until_out(PKT, 400, ok);
    repeat (20) tick();
    parse_stream(nn, nu, nb);
    n_checks++; if (drop_byte_count !== sat(2)) $display("FAIL hunt_drop_cnt: got %0d want 2", drop_byte_count); else n_pass++;
    n_checks++; if (nu != 1 || nb != 0 || nn != 0 || out_q.size() != PKT)
      $display("FAIL hunt_packet: got null=%0d user=%0d bad=%0d len=%0d want 0/1/0/%0d", nn, nu, nb, out_q.size(), PKT); else n_pass++;
  endtask

  task automatic test_late_user();
    bit ok; int nn, nu, nb;
    do_reset();
    enable = 1'b1; drive();
    run_until_out(5, 50, ok);
    push_pkt(); drive();
    run_until_out(PKT + 1, 400, ok);
    enable = 1'b0;
    run_until_out(2*PKT, 400, ok);
    repeat (20) tick();
    parse_stream(nn, nu, nb);
    n_checks++; if (out_q[3] !== 8'h10 || out_q[PKT] !== 8'h47 || out_q[PKT+1] !== user_q[1])
      $display("FAIL late_order: got %h/%h want null then user", out_q[3], out_q[PKT+1]); else n_pass++;
    n_checks++; if (nn != 1 || nu != 1 || nb != 0 || out_q.size() != 2*PKT)
      $display("FAIL late_stream: got null=%0d user=%0d bad=%0d len=%0d want 1/1/0/%0d", nn, nu, nb, out_q.size(), 2*PKT); else n_pass++;
    n_checks++; if (null_pkt_count !== sat(1)) $display("FAIL late_null_cnt: got %0d want 1", null_pkt_count); else n_pass++;
  endtask

  task automatic test_random_ack();
    int nn, nu, nb, c, nj;
    do_reset();
    ack_pct = 50; gap_pct = 30;
    enable = 1'b1; drive();
    for (int k = 0; k < 6; k++) begin
      nj = $urandom_range(2);
      for (int j = 0; j < nj; j++) push_junk(8'($urandom_range(255)));
      push_pkt();
      repeat ($urandom_range(400, 50)) tick();
    end
    c = 0;
    while (in_q.size() > 0 && c < 20000) begin tick(); c++; end
    n_checks++; if (in_q.size() != 0) $display("FAIL rand_drain: got %0d bytes left want 0", in_q.size()); else n_pass++;
    enable = 1'b0;
    repeat (1000) tick();
    parse_stream(nn, nu, nb);
    n_checks++; if (stab_viol != 0) $display("FAIL rand_stable: got %0d violations want 0", stab_viol); else n_pass++;
    n_checks++; if (nu != 6 || nb != 0 || (out_q.size() % PKT) != 0)
      $display("FAIL rand_stream: got user=%0d bad=%0d len=%0d want 6/0/multiple of %0d", nu, nb, out_q.size(), PKT); else n_pass++;
    n_checks++; if (null_pkt_count !== sat(nn)) $display("FAIL rand_null_cnt: got %0d want %0d", null_pkt_count, sat(nn)); else n_pass++;
    n_checks++; if (drop_byte_count !== sat(junk_cnt)) $display("FAIL rand_drop_cnt: got %0d want %0d", drop_byte_count, sat(junk_cnt)); else n_pass++;
    n_checks++; if (data_out_req !== 1'b0) $display("FAIL rand_idle: got req %b want 0", data_out_req); else n_pass++;
  endtask

  task automatic test_enable_and_reset();
    bit ok; int nn, nu, nb;
    do_reset();
    push_pkt(); enable = 1'b1; drive();
    run_until_out(100, 300, ok);
    enable = 1'b0;
    run_until_out(PKT, 400, ok);
    repeat (30) tick();
    parse_stream(nn, nu, nb);
    n_checks++; if (out_q.size() != PKT || nu != 1 || nb != 0)
      $display("FAIL en_drop_packet: got len=%0d user=%0d bad=%0d want %0d/1/0", out_q.size(), nu, nb, PKT); else n_pass++;
    n_checks++; if (data_out_req !== 1'b0) $display("FAIL en_drop_idle: got req %b want 0", data_out_req); else n_pass++;

    do_reset();
    push_pkt(); enable = 1'b1; drive();
    run_until_out(50, 300, ok);
    rst_n = 1'b0; #1;
    n_checks++; if (data_out_req !== 1'b0 || data_in_ack !== 1'b0)
      $display("FAIL rst_mid_pkt: got req=%b ack=%b want 0/0", data_out_req, data_in_ack); else n_pass++;
    clear_model();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b1; drive();
    run_until_out(PKT, 400, ok);
    parse_stream(nn, nu, nb);
    n_checks++; if (out_q[0] !== 8'h47) $display("FAIL rst_first_byte: got %h want 47", out_q[0]); else n_pass++;
    n_checks++; if (nn != 1 || nb != 0) $display("FAIL rst_first_pkt: got null=%0d bad=%0d want 1/0", nn, nb); else n_pass++;
  endtask

  task automatic test_saturation();
    bit ok; int c;
    do_reset();
    for (int i = 1; i <= 20; i++) push_junk(8'(i));
    enable = 1'b1; drive();
    c = 0;
    while (in_q.size() > 0 && c < 200) begin tick(); c++; end
    n_checks++; if (drop_byte_count !== sat(20)) $display("FAIL sat_drop_cnt: got %0d want %0d", drop_byte_count, sat(20)); else n_pass++;
    run_until_out(18*PKT, 5000, ok);
    tick();
    n_checks++; if (null_pkt_count !== sat(18)) $display("FAIL sat_null_cnt: got %0d want %0d", null_pkt_count, sat(18)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_null_stream();
    test_user_passthrough();
    test_hunt();
    test_late_user();
    test_random_ack();
    test_enable_and_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
